// File: rtl/hawk_page_cmprsr_pkg.sv
// Shared constants, trailer layout and FSM state type for the page compressor.
package hawk_page_cmprsr_pkg;

  localparam int CMP_LINE_W         = 512;
  localparam int CMP_LINES_PER_PAGE = 64;
  localparam int CMP_MAX_DATA_LINES = 1;
  localparam int CMP_INCOMP_SIZE    = 4096;
  localparam int CMP_SIZE_W         = 14;

  // Compressed sizes that fit a bucket: trailer only, or trailer + one line.
  localparam int CMP_NUM_SIZES = 2;
  localparam int CMP_SIZE_LIST [CMP_NUM_SIZES] = '{64, 128};

  // Trailer beat layout: bitmap of non-zero lines, then the non-zero count.
  localparam int CMP_TRL_BMAP_LSB = 0;
  localparam int CMP_TRL_BMAP_W   = 64;
  localparam int CMP_TRL_CNT_LSB  = 64;
  localparam int CMP_TRL_CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONSUME,
    ST_EMIT_LINE,
    ST_EMIT_TRAILER,
    ST_DONE
  } cmprsr_state_t;

  // Bucket size for a compressible page holding zero or one data line.
  function automatic logic [CMP_SIZE_W-1:0] cmp_size_bytes(input logic has_line);
    return CMP_SIZE_W'(has_line ? CMP_SIZE_LIST[1] : CMP_SIZE_LIST[0]);
  endfunction

endpackage

// File: rtl/hawk_page_cmprsr_if.sv
// Manager / read-FIFO / output-stream bundle of the page compressor.
interface hawk_page_cmprsr_if
  import hawk_page_cmprsr_pkg::*;
#(
  parameter int DATA_W = CMP_LINE_W
) ();
  logic                  comp_start;
  logic                  rdfifo_empty;
  logic [DATA_W-1:0]     rdfifo_rdata;
  logic                  rdfifo_pop;
  logic                  cout_valid;
  logic                  cout_ready;
  logic [DATA_W-1:0]     cout_data;
  logic                  cout_last;
  logic                  comp_done;
  logic [CMP_SIZE_W-1:0] comp_size;
  logic                  comp_incompressible;

  // Compressor side.
  modport slave (
    input  comp_start, rdfifo_empty, rdfifo_rdata, cout_ready,
    output rdfifo_pop, cout_valid, cout_data, cout_last,
           comp_done, comp_size, comp_incompressible
  );

  // Manager / FIFO / consumer side.
  modport master (
    output comp_start, rdfifo_empty, rdfifo_rdata, cout_ready,
    input  rdfifo_pop, cout_valid, cout_data, cout_last,
           comp_done, comp_size, comp_incompressible
  );
endinterface

// File: rtl/hawk_page_cmprsr_zline.sv
// Purely combinational zero-line detector built from 64-bit lanes; lanes
// with lane_en low are ignored so finer-grain schemes can reuse it.
module hawk_zline_detect #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 64
) (
  input  logic [DATA_W-1:0]        data,
  input  logic [DATA_W/LANE_W-1:0] lane_en,
  output logic                     line_zero
);
  localparam int NLANES = DATA_W / LANE_W;

  logic [NLANES-1:0] lane_zero;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign lane_zero[gi] = ~|data[gi*LANE_W +: LANE_W];
  end

  assign line_zero = &(lane_zero | ~lane_en);
endmodule

// File: rtl/hawk_page_cmprsr.sv
// Zero-line page compressor: drains one page from the read FIFO, streams the
// non-zero lines followed by a bitmap trailer, and reports the bucket size.
module hawk_page_cmprsr
  import hawk_page_cmprsr_pkg::*;
#(
  parameter int DATA_W         = CMP_LINE_W,
  parameter int LINES_PER_PAGE = CMP_LINES_PER_PAGE,
  parameter int MAX_DATA_LINES = CMP_MAX_DATA_LINES,
  parameter int INCOMP_SIZE    = CMP_INCOMP_SIZE
) (
  input logic               clk_i,
  input logic               rst_ni,
  hawk_page_cmprsr_if.slave bus
);
  localparam int LC_W   = $clog2(LINES_PER_PAGE) + 1;
  localparam int NZ_W   = $clog2(MAX_DATA_LINES + 2);
  localparam int LANE_W = 64;
  localparam int NLANES = DATA_W / LANE_W;
  localparam logic [LC_W-1:0] LAST_IDX = LC_W'(LINES_PER_PAGE - 1);
  localparam logic [LC_W-1:0] PAGE_CNT = LC_W'(LINES_PER_PAGE);
  localparam logic [NZ_W-1:0] NZ_MAX   = NZ_W'(MAX_DATA_LINES);
  localparam logic [NZ_W-1:0] NZ_SAT   = NZ_W'(MAX_DATA_LINES + 1);

  cmprsr_state_t             state_reg;
  logic [LC_W-1:0]           line_cnt_reg;
  logic [NZ_W-1:0]           nz_cnt_reg;
  logic [LINES_PER_PAGE-1:0] bitmap_reg;
  logic                      incomp_reg;
  logic                      cout_valid_reg;
  logic                      cout_last_reg;
  logic [DATA_W-1:0]         cout_data_reg;
  logic                      comp_done_reg;
  logic [CMP_SIZE_W-1:0]     comp_size_reg;
  logic                      comp_incomp_reg;

  logic                      pop;
  logic                      line_zero;
  logic                      take;
  logic                      is_last;
  logic [LINES_PER_PAGE-1:0] bitmap_upd;
  logic [DATA_W-1:0]         trailer;

  hawk_zline_detect #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_zline (
    .data      (bus.rdfifo_rdata),
    .lane_en   ({NLANES{1'b1}}),
    .line_zero (line_zero)
  );

  assign pop     = (state_reg == ST_CONSUME) && !bus.rdfifo_empty;
  assign take    = !line_zero && (nz_cnt_reg < NZ_MAX) && !incomp_reg;
  assign is_last = (line_cnt_reg == LAST_IDX);

  // Bitmap including the line being popped this cycle (only while popping).
  always_comb begin
    bitmap_upd = bitmap_reg;
    if (pop && !line_zero) bitmap_upd[line_cnt_reg[LC_W-2:0]] = 1'b1;
  end

  // Trailer beat assembled from the up-to-date bitmap and non-zero count.
  always_comb begin
    trailer = '0;
    trailer[CMP_TRL_BMAP_LSB +: CMP_TRL_BMAP_W] = CMP_TRL_BMAP_W'(bitmap_upd);
    trailer[CMP_TRL_CNT_LSB +: CMP_TRL_CNT_W]   = CMP_TRL_CNT_W'(nz_cnt_reg);
  end

  // Main FSM: page counters plus all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      line_cnt_reg    <= '0;
      nz_cnt_reg      <= '0;
      bitmap_reg      <= '0;
      incomp_reg      <= 1'b0;
      cout_valid_reg  <= 1'b0;
      cout_last_reg   <= 1'b0;
      cout_data_reg   <= '0;
      comp_done_reg   <= 1'b0;
      comp_size_reg   <= '0;
      comp_incomp_reg <= 1'b0;
    end else begin
      comp_done_reg <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.comp_start) begin
            line_cnt_reg    <= '0;
            nz_cnt_reg      <= '0;
            bitmap_reg      <= '0;
            incomp_reg      <= 1'b0;
            comp_incomp_reg <= 1'b0;
            state_reg       <= ST_CONSUME;
          end
        end
        ST_CONSUME: begin
          if (pop) begin
            line_cnt_reg <= line_cnt_reg + 1'b1;
            bitmap_reg   <= bitmap_upd;
            if (take) begin
              nz_cnt_reg     <= nz_cnt_reg + 1'b1;
              cout_data_reg  <= bus.rdfifo_rdata;
              cout_valid_reg <= 1'b1;
              state_reg      <= ST_EMIT_LINE;
            end else begin
              // A non-zero line that cannot be taken means the page overflowed.
              if (!line_zero) begin
                incomp_reg <= 1'b1;
                if (nz_cnt_reg != NZ_SAT) nz_cnt_reg <= nz_cnt_reg + 1'b1;
              end
              if (is_last) begin
                if (incomp_reg || !line_zero) begin
                  comp_size_reg   <= CMP_SIZE_W'(INCOMP_SIZE);
                  comp_incomp_reg <= 1'b1;
                  comp_done_reg   <= 1'b1;
                  state_reg       <= ST_DONE;
                end else begin
                  cout_data_reg  <= trailer;
                  cout_valid_reg <= 1'b1;
                  cout_last_reg  <= 1'b1;
                  state_reg      <= ST_EMIT_TRAILER;
                end
              end
            end
          end
        end
        ST_EMIT_LINE: begin
          if (cout_valid_reg && bus.cout_ready) begin
            if (line_cnt_reg == PAGE_CNT) begin
              cout_data_reg <= trailer;
              cout_last_reg <= 1'b1;
              state_reg     <= ST_EMIT_TRAILER;
            end else begin
              cout_valid_reg <= 1'b0;
              state_reg      <= ST_CONSUME;
            end
          end
        end
        ST_EMIT_TRAILER: begin
          if (cout_valid_reg && bus.cout_ready) begin
            cout_valid_reg  <= 1'b0;
            cout_last_reg   <= 1'b0;
            comp_size_reg   <= cmp_size_bytes(nz_cnt_reg != '0);
            comp_incomp_reg <= 1'b0;
            comp_done_reg   <= 1'b1;
            state_reg       <= ST_DONE;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdfifo_pop          = pop;
  assign bus.cout_valid          = cout_valid_reg;
  assign bus.cout_last           = cout_last_reg;
  assign bus.cout_data           = cout_data_reg;
  assign bus.comp_done           = comp_done_reg;
  assign bus.comp_size           = comp_size_reg;
  assign bus.comp_incompressible = comp_incomp_reg;
endmodule
